paddle_ctrl: RTL
================

# paddle_ctrl

Player paddle controller for the VGA breakout game. It synchronises and debounces the two raw push-buttons and moves the paddle once per frame on `refr_tick`, with a speed ramp and edge clamping. It drives `paddle_x`/`paddle_y` into the ball stage, and `paddle_on`/`paddle_rgb` into the pixel colour mux.

## Interface
- `MAX_X`, 640: visible width in pixels.
- `PADDLE_W`, 100: paddle width in pixels. The ball stage's collision test uses 100.
- `PADDLE_H`, 8: paddle height in pixels.
- `PADDLE_Y`, 464: fixed top row of the paddle.
- `DB_CYCLES`, 250000: number of consecutive stable clk cycles needed to accept a button change.
- `SPEED_MIN`, 2: pixels per frame on movement start.
- `SPEED_MAX`, 8: speed ceiling in pixels per frame.
- `RAMP_FRAMES`, 8: number of frames of held direction per +1 speed step.
- `PADDLE_COLOR`, 12'h0FF: RGB444 colour.
- `clk` input 1: pixel clock. Single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `refr_tick` input 1: one-cycle pulse at the start of vertical blank, once per frame.
- `btn_left` input 1: raw, asynchronous, active-high.
- `btn_right` input 1: raw, asynchronous, active-high.
- `x` input 10: current pixel column.
- `y` input 10: current pixel row.
- `paddle_x` output 10: registered left edge of the paddle.
- `paddle_y` output 10: constant `PADDLE_Y`.
- `paddle_on` output 1: combinational; high when the current pixel is inside the paddle.
- `paddle_rgb` output 12: constant `PADDLE_COLOR`.

## Operation
- **Synchroniser:** each button passes through a 2-FF synchroniser.
- **Debouncer:** one per button.
  - Holds a debounced level `db` and a counter `cnt` of width clog2(DB_CYCLES+1).
  - While sync == db: cnt = 0.
  - Otherwise cnt increments. When cnt reaches DB_CYCLES-1, db toggles and cnt = 0.
  - A glitch shorter than DB_CYCLES cycles never changes `db`.
- **Direction decode:** computed from the debounced levels.
  - Left only: L.
  - Right only: R.
  - Both or neither: NONE.
- **FSM:** states IDLE, MOVE_L, MOVE_R.
  - The state is evaluated only in cycles where `refr_tick`=1. It holds at all other times.
  - NONE leads to IDLE.
  - L leads to MOVE_L; R leads to MOVE_R.
  - Entering a move state from IDLE or from the opposite move state sets speed = SPEED_MIN and ramp_cnt = 0. A reversal goes directly to the new move state with no IDLE frame.
  - Staying in the same move state increments ramp_cnt. When ramp_cnt reaches RAMP_FRAMES-1, ramp_cnt = 0 and speed = min(speed+1, SPEED_MAX).
  - In IDLE, speed = SPEED_MIN and ramp_cnt = 0.
- **Position update:** on the same tick, using the next state and its speed.
  - MOVE_L: paddle_x = (paddle_x < speed) ? 0 : paddle_x - speed.
  - MOVE_R: paddle_x = (paddle_x + speed > MAX_X-PADDLE_W) ? MAX_X-PADDLE_W : paddle_x + speed.
  - Do the right-move sum in 11 bits so it cannot wrap.
  - paddle_x is always in [0, MAX_X-PADDLE_W] = [0, 540].
- **paddle_on:** high when (x >= paddle_x) && (x < paddle_x+PADDLE_W) && (y >= PADDLE_Y) && (y < PADDLE_Y+PADDLE_H). Use 11-bit sums.
- **Reset values:**
  - paddle_x = (MAX_X-PADDLE_W)/2 = 270.
  - State IDLE, speed = SPEED_MIN, ramp_cnt = 0.
  - db = 0, cnt = 0, synchroniser FFs = 0.
  - paddle_y, paddle_rgb are constant; paddle_on is combinational.
- **Reset mid-movement:** rst wins over refr_tick in the same cycle. The paddle recentres to 270 on the next edge.

## Timing
- Raw button edge to `db` change: 2 synchroniser cycles + DB_CYCLES cycles, for a press held continuously.
- `db` change to `paddle_x` change: at the next `refr_tick`. `paddle_x` updates on the clk edge ending the tick cycle and is stable for the rest of the frame.
- The ball stage samples `paddle_x` on the same tick, so it sees the previous frame's value. This one-frame lag is required and must not be bypassed combinationally.
- `paddle_on` has zero latency relative to `x`/`y`.
- Throughput: at most one position update per frame. Extra ticks are impossible by the definition of `refr_tick`.

## Test plan
- **Reset and render:** apply reset (DB_CYCLES=4 for sim), then scan x=270..369, y=464..471.
  - paddle_x=270, paddle_y=464.
  - paddle_on=1 exactly inside that window; 0 at x=269, x=370, y=463 and y=472.
- **Debounce:** a 3-cycle pulse on btn_right leaves db=0 and no movement. Holding it for 10 cycles gives db=1 within 2+4 cycles.
- **Ramp:** hold right for 8 ticks. The moves are +2 each, giving paddle_x=286. Ticks 9–16 move +3 each, then the ramp continues, saturating at +8 per frame.
- **Clamp:** from paddle_x=536, moving right at speed 8 gives 540 and stays 540. Moving left from paddle_x=3 at speed 4 gives 0 and stays 0.
- **Reversal and both-pressed:** at speed 5 moving right, switch to left. The next tick moves -2 (speed reset). Pressing both buttons gives IDLE with no movement.
- **Reset mid-move:** assert rst in the same cycle as refr_tick while in MOVE_R. Next cycle: paddle_x=270, state IDLE.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced two-button paddle mover with per-frame speed ramp and edge clamping.
module paddle_ctrl #(
    parameter int          MAX_X        = 640,
    parameter int          PADDLE_W     = 100,
    parameter int          PADDLE_H     = 8,
    parameter int          PADDLE_Y     = 464,
    parameter int          DB_CYCLES    = 250000,
    parameter int          SPEED_MIN    = 2,
    parameter int          SPEED_MAX    = 8,
    parameter int          RAMP_FRAMES  = 8,
    parameter logic [11:0] PADDLE_COLOR = 12'h0FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refr_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [9:0]  paddle_x,
    output logic [9:0]  paddle_y,
    output logic        paddle_on,
    output logic [11:0] paddle_rgb
);
    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int SW = $clog2(SPEED_MAX + 1);
    localparam int RW = $clog2(RAMP_FRAMES + 1);
    localparam logic [10:0] X_MAX = 11'(MAX_X - PADDLE_W);

    logic [1:0]    raw, s1, s2, db;
    logic [CW-1:0] cnt [2];
    state_t        state, nstate;
    logic [SW-1:0] speed, nspeed;
    logic [RW-1:0] ramp_cnt, nramp;
    logic          same, wrap;
    logic [10:0]   sum;
    logic [9:0]    nx;

    assign raw = {btn_right, btn_left};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            db  <= '0;
            cnt <= '{default: '0};
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int b = 0; b < 2; b++) begin
                if (s2[b] == db[b]) cnt[b] <= '0;
                else if (cnt[b] == CW'(DB_CYCLES - 1)) begin
                    db[b]  <= ~db[b];
                    cnt[b] <= '0;
                end else cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end

    // next state/speed/position, committed only on refr_tick
    always_comb begin
        nstate = (db == 2'b01) ? MOVE_L : (db == 2'b10) ? MOVE_R : IDLE;
        same   = (nstate == state) && (nstate != IDLE);
        wrap   = ramp_cnt == RW'(RAMP_FRAMES - 1);
        nspeed = !same ? SW'(SPEED_MIN) : (wrap && speed < SW'(SPEED_MAX)) ? speed + 1'b1 : speed;
        nramp  = (!same || wrap) ? '0 : ramp_cnt + 1'b1;
        sum    = {1'b0, paddle_x} + 11'(nspeed);
        nx     = (nstate == MOVE_L) ? ((paddle_x < 10'(nspeed)) ? '0 : paddle_x - 10'(nspeed)) :
                 (nstate == MOVE_R) ? ((sum > X_MAX) ? X_MAX[9:0] : sum[9:0]) : paddle_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            speed    <= SW'(SPEED_MIN);
            ramp_cnt <= '0;
            paddle_x <= 10'((MAX_X - PADDLE_W) / 2);
        end else if (refr_tick) begin
            state    <= nstate;
            speed    <= nspeed;
            ramp_cnt <= nramp;
            paddle_x <= nx;
        end
    end

    assign paddle_y   = 10'(PADDLE_Y);
    assign paddle_rgb = PADDLE_COLOR;
    assign paddle_on  = ({1'b0, x} >= {1'b0, paddle_x}) && ({1'b0, x} < {1'b0, paddle_x} + 11'(PADDLE_W)) &&
                        ({1'b0, y} >= 11'(PADDLE_Y)) && ({1'b0, y} < 11'(PADDLE_Y + PADDLE_H));
endmodule
